// File: rtl/data_memory_unit.sv
// Byte-addressable MEM-stage data memory: word/half/byte stores, sign-extending
// registered loads, suppression and flagging of misaligned or reserved-width accesses.
module data_memory_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        R_Enable,
    input  logic        W_Enable,
    input  logic [1:0]  R_Width,
    input  logic [1:0]  W_Width,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Misaligned
);

    typedef enum logic [1:0] {
        WIDTH_WORD = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_BYTE = 2'd2,
        WIDTH_RSVD = 2'd3
    } width_e;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_off;
    logic             unused_addr_hi;

    logic [31:0] read_data_q, read_data_d;
    logic        read_valid_q, read_valid_d;
    logic        misaligned_q, misaligned_d;

    logic        rd_legal, wr_legal;
    logic        rd_accept, wr_accept;
    logic [31:0] rd_word;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    // Addresses wrap modulo the array size; the high bits are deliberately dropped.
    assign word_idx       = Address[IDX_W+1:2];
    assign byte_off       = Address[1:0];
    assign unused_addr_hi = ^Address[31:IDX_W+2];

    // NOTE: every variable gets a default before the case so that no path can
    // leave it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        rd_legal = 1'b0;
        case (width_e'(R_Width))
            WIDTH_WORD: rd_legal = (byte_off == 2'd0);
            WIDTH_HALF: rd_legal = ~byte_off[0];
            WIDTH_BYTE: rd_legal = 1'b1;
            default:    rd_legal = 1'b0;
        endcase

        wr_legal = 1'b0;
        wr_be    = 4'b0000;
        wr_data  = WriteData;
        case (width_e'(W_Width))
            WIDTH_WORD: begin
                wr_legal = (byte_off == 2'd0);
                wr_be    = 4'b1111;
            end
            WIDTH_HALF: begin
                wr_legal = ~byte_off[0];
                wr_be    = byte_off[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{WriteData[15:0]}};
            end
            WIDTH_BYTE: begin
                wr_legal = 1'b1;
                wr_be    = 4'b0001 << byte_off;
                wr_data  = {4{WriteData[7:0]}};
            end
            default: begin
                wr_legal = 1'b0;
                wr_be    = 4'b0000;
            end
        endcase
    end

    assign rd_accept = R_Enable & rd_legal;
    assign wr_accept = W_Enable & wr_legal;

    // The array is read combinationally before the edge, so a same-edge store
    // is never visible to the load it coincides with.
    always_comb begin
        rd_word = mem[word_idx];
        rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte = 8'h00;
        case (byte_off)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase

        read_data_d = read_data_q;
        if (rd_accept) begin
            case (width_e'(R_Width))
                WIDTH_WORD: read_data_d = rd_word;
                WIDTH_HALF: read_data_d = {{16{rd_half[15]}}, rd_half};
                WIDTH_BYTE: read_data_d = {{24{rd_byte[7]}}, rd_byte};
                default:    read_data_d = read_data_q;
            endcase
        end
        read_valid_d = rd_accept;
        misaligned_d = (R_Enable & ~rd_legal) | (W_Enable & ~wr_legal);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            read_data_q  <= 32'h0000_0000;
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    // NOTE: the array has no reset; clearing it would force it into flops and
    // contents must survive a reset anyway.
    always_ff @(posedge Clk) begin
        if (Rst && wr_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign ReadData   = read_data_q;
    assign ReadValid  = read_valid_q;
    assign Misaligned = misaligned_q;

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Byte-addressable data memory for the MEM stage of the pipelined MIPS datapath, directly downstream of the instruction controller. It consumes the decoded `R_Enable`, `W_Enable`, `R_Width` and `W_Width` signals together with the ALU-computed address and the store data. It performs word, halfword and byte stores and sign-extending loads, with a registered one-cycle read. Misaligned or reserved-width accesses are suppressed and flagged.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two.
- `IDX_W`, 10: log2(`DEPTH_WORDS`); word index width.

Ports:
- `Clk`  in  1  the single clock; all state updates on the rising edge.
- `Rst`  in  1  reset, synchronous, active-low.
- `Address`  in  32  byte address from the ALU.
- `WriteData`  in  32  store data (rt register value).
- `R_Enable`  in  1  load request this cycle.
- `W_Enable`  in  1  store request this cycle.
- `R_Width`  in  2  load width: 0 = word, 1 = half (lh), 2 = byte (lb), 3 = reserved.
- `W_Width`  in  2  store width: 0 = sw, 1 = sh, 2 = sb, 3 = reserved.
- `ReadData`  out  32  registered, sign-extended load result.
- `ReadValid`  out  1  1 for the cycle in which `ReadData` holds a new load result.
- `Misaligned`  out  1  one-cycle pulse marking a suppressed access.

## Operation
- Array: `DEPTH_WORDS` x 32 bits. Word index = `Address[IDX_W+1:2]`; upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- Byte lanes are little-endian:
  - byte offset k = `Address[1:0]` maps to bits [8k+7:8k];
  - halfword offset 0 maps to [15:0], offset 2 maps to [31:16].
- Alignment rules:
  - word accesses require `Address[1:0]` = 0;
  - half accesses require `Address[0]` = 0;
  - byte accesses are always aligned.
- Store on an edge with `Rst` = 1, `W_Enable` = 1, aligned, width ≠ 3:
  - sw writes all 4 lanes;
  - sh writes `WriteData[15:0]` into the selected half;
  - sb writes `WriteData[7:0]` into the selected byte;
  - all other lanes are unchanged.
- Load on an edge with `Rst` = 1, `R_Enable` = 1, aligned, width ≠ 3:
  - `ReadData` ← word, or the selected half sign-extended from bit 15, or the selected byte sign-extended from bit 7;
  - `ReadValid` ← 1.
- Idle edge (no accepted load):
  - `ReadValid` ← 0;
  - `ReadData` holds its previous value.
- Suppressed access (misaligned, or width = 3, on an enabled port):
  - no array change, `ReadData` holds, `ReadValid` ← 0;
  - `Misaligned` ← 1 for one cycle, then 0.
- Simultaneous load and store on the same edge:
  - both execute;
  - the load returns the contents before the write (read-before-write), including when both hit the same word;
  - `Misaligned` is set if either access is suppressed, and the other access still proceeds.
- Reset (`Rst` = 0 at an edge):
  - `ReadData` ← 0, `ReadValid` ← 0, `Misaligned` ← 0;
  - array contents are NOT cleared, and no store is performed that edge;
  - asserting reset mid-sequence discards any pending load result.
- X on `R_Width`/`W_Width` while the matching enable is 0 is legal and has no effect.

## Timing
- Load latency: 1 cycle. Inputs are sampled at edge N; `ReadData`/`ReadValid` are valid after edge N and until edge N+1.
- Store takes effect at edge N. A load sampled at edge N+1 to the same address sees the new data.
- Back-to-back loads every cycle are supported at full throughput. `ReadValid` stays high continuously.
- `Misaligned` asserts after the offending edge, for exactly one cycle per offending request.
- There are no stalls and no handshake back-pressure; every request completes or is suppressed in one cycle.

## Test plan
- **Reset and outputs:** hold `Rst` = 0 for 2 cycles → `ReadData` = 0x00000000, `ReadValid` = 0, `Misaligned` = 0.
- **Word and byte round-trip:**
  - sw 0x8899AABB to addr 0x10, then lw 0x10 → 0x8899AABB one cycle later with `ReadValid` = 1;
  - then lb 0x13 → 0xFFFFFF88, and lb 0x10 → 0xFFFFFFBB.
- **Sub-word stores and sign extension:**
  - sh 0x00001234 to 0x12 over word 0xFFFFFFFF, then lw 0x10 → 0x1234FFFF;
  - sb 0x7F to 0x11, then lh 0x10 → 0x00007FFF.
- **Misalignment and reserved width:**
  - lw 0x22 → `Misaligned` pulse, `ReadValid` = 0, `ReadData` unchanged;
  - sh 0x21 → `Misaligned` pulse, memory unchanged;
  - `W_Width` = 3 → `Misaligned` pulse, no write.
- **Simultaneous load and store to word 0x40 (old value 0x11111111):** sw 0x22222222 with lw 0x40 on the same edge → load returns 0x11111111; the next lw returns 0x22222222.
- **Wrap and reset mid-run:**
  - sw to address `4*DEPTH_WORDS` + 8, then lw 8 → same data;
  - issue a lw, then assert `Rst` on the next edge → `ReadValid` = 0 and `ReadData` = 0, while array contents survive for a later lw.
